// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : Tracks in-flight destinations; picks forwarding sources for ID
//            operands and raises load-use / interlock stalls.
// Revision : 1.0  initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int REG_W    = 4,
    parameter int NUM_SRC  = 3,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       id_valid,
    input  logic [REG_W-1:0]           id_dest,
    input  logic                       id_wb_en,
    input  logic                       id_mem_read,
    input  logic [NUM_SRC*REG_W-1:0]   src_addr,
    input  logic [NUM_SRC-1:0]         src_used,
    output logic [NUM_SRC*SEL_W-1:0]   sel,
    output logic                       stall,
    output logic [15:0]                stall_cnt
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // Entry 1 is the EXE stage, entry DEPTH the WB stage.
    logic [DEPTH:1]     r_valid;
    logic [DEPTH:1]     r_load;
    logic [REG_W-1:0]   r_dest [1:DEPTH];
    logic [15:0]        r_stall_cnt;

    logic [NUM_SRC-1:0] w_any;
    logic [NUM_SRC-1:0] w_load_hz;
    logic               w_stall;

    genvar s, k;
    generate
        for (s = 0; s < NUM_SRC; s++) begin : g_src
            logic [DEPTH:1]   w_match;
            logic [SEL_W-1:0] w_ks;
            logic             w_anys;
            logic             w_hzs;

            for (k = 1; k <= DEPTH; k++) begin : g_ent
                assign w_match[k] = src_used[s] & r_valid[k] &
                                    (r_dest[k] == src_addr[s*REG_W +: REG_W]);
            end

            // Scan oldest to youngest so the youngest producer is the last writer.
            always_comb begin
                w_ks   = '0;
                w_anys = 1'b0;
                w_hzs  = 1'b0;
                for (int j = DEPTH; j >= 1; j--) begin
                    if (w_match[j]) begin
                        w_ks   = SEL_W'(j);
                        w_anys = 1'b1;
                        w_hzs  = r_load[j] && (j <= LOAD_LAT);
                    end
                end
            end

            assign w_any[s]     = w_anys;
            assign w_load_hz[s] = w_hzs;
            assign sel[s*SEL_W +: SEL_W] = (id_valid && en && !w_stall) ? w_ks : '0;
        end
    endgenerate

    assign w_stall   = id_valid & (en ? (|w_load_hz) : (|w_any));
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_load      <= '0;
            r_stall_cnt <= '0;
            for (int j = 1; j <= DEPTH; j++) begin
                r_dest[j] <= '0;
            end
        end else begin
            // A stalled ID instruction enters the pipe as a bubble.
            r_valid[1] <= flush ? 1'b0 : (id_valid & id_wb_en & ~w_stall);
            r_load[1]  <= id_mem_read;
            r_dest[1]  <= id_dest;
            for (int j = 2; j <= DEPTH; j++) begin
                r_valid[j] <= flush ? 1'b0 : r_valid[j-1];
                r_load[j]  <= r_load[j-1];
                r_dest[j]  <= r_dest[j-1];
            end
            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Purpose  : Scenario tasks with an expected-result queue for fwd_hazard_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_dest;
    logic        id_wb_en;
    logic        id_mem_read;
    logic [11:0] src_addr;
    logic [2:0]  src_used;
    logic [5:0]  sel;
    logic        stall;
    logic [15:0] stall_cnt;
    logic [11:0] sel_deep;
    logic        stall_deep;
    logic [15:0] cnt_deep;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        flush;
        logic        v;
        logic [3:0]  dest;
        logic        wb;
        logic        ld;
        logic [11:0] srcs;
        logic [2:0]  used;
    } stim_t;

    typedef struct packed {
        logic [5:0]  sel;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    fwd_hazard_unit dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_dest     (id_dest),
        .id_wb_en    (id_wb_en),
        .id_mem_read (id_mem_read),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .sel         (sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    // Deep tracker: stalls 15 of every 16 cycles, used to reach counter saturation quickly.
    fwd_hazard_unit #(.DEPTH(15), .SEL_W(4)) dut_deep (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_dest     (id_dest),
        .id_wb_en    (id_wb_en),
        .id_mem_read (id_mem_read),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .sel         (sel_deep),
        .stall       (stall_deep),
        .stall_cnt   (cnt_deep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic r, input logic e, input logic f, input logic v,
                                 input logic [3:0] d, input logic wb, input logic ld,
                                 input logic [11:0] s, input logic [2:0] u);
        return '{rst:r, en:e, flush:f, v:v, dest:d, wb:wb, ld:ld, srcs:s, used:u};
    endfunction

    function automatic exp_t ex(input logic [5:0] s, input logic st, input logic [15:0] c);
        return '{sel:s, stall:st, cnt:c};
    endfunction

    task automatic apply(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        rst         = s.rst;
        en          = s.en;
        flush       = s.flush;
        id_valid    = s.v;
        id_dest     = s.dest;
        id_wb_en    = s.wb;
        id_mem_read = s.ld;
        src_addr    = s.srcs;
        src_used    = s.used;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = H; flush = L; id_valid = L; id_wb_en = L; id_mem_read = L;
        src_used = 3'b000; src_addr = 12'h000; id_dest = 4'd0;
        @(posedge clk);
        #1;
        rst = L;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        st.push_back(mk(H,H,L,H,4'd3,H,L,12'h333,3'b111)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(H,H,L,H,4'd3,H,L,12'h333,3'b111)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd3,H,L,12'h333,3'b111)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd3,H,L,12'h333,3'b111)); xq.push_back(ex(6'b010101,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd5,H,H,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(H,H,L,H,4'd6,H,L,12'h005,3'b001)); xq.push_back(ex(6'b000000,H,16'd0));
        st.push_back(mk(L,H,L,H,4'd6,H,L,12'h005,3'b001)); xq.push_back(ex(6'b000000,L,16'd0));
        foreach (st[i]) begin
            apply(st[i], xq[i]);
            #3;
            e = exp_q.pop_front();
            n_total++;
            if ({sel, stall, stall_cnt} !== {e.sel, e.stall, e.cnt}) begin
                n_bad++;
                $display("FAIL reset[%0d]: got sel=%b stall=%b cnt=%0d, want sel=%b stall=%b cnt=%0d",
                         i, sel, stall, stall_cnt, e.sel, e.stall, e.cnt);
            end
        end
    endtask

    task automatic test_fwd_single();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(L,H,L,H,4'd3,H,L,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h003,3'b001)); xq.push_back(ex(6'b000001,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h003,3'b001)); xq.push_back(ex(6'b000010,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h300,3'b100)); xq.push_back(ex(6'b110000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h300,3'b100)); xq.push_back(ex(6'b000000,L,16'd0));
        foreach (st[i]) begin
            apply(st[i], xq[i]);
            #3;
            e = exp_q.pop_front();
            n_total++;
            if ({sel, stall, stall_cnt} !== {e.sel, e.stall, e.cnt}) begin
                n_bad++;
                $display("FAIL fwd_single[%0d]: got sel=%b stall=%b cnt=%0d, want sel=%b stall=%b cnt=%0d",
                         i, sel, stall, stall_cnt, e.sel, e.stall, e.cnt);
            end
        end
    endtask

    task automatic test_youngest();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(L,H,L,H,4'd3,H,L,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd3,H,L,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h037,3'b011)); xq.push_back(ex(6'b000100,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd5,H,H,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd5,H,L,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h005,3'b001)); xq.push_back(ex(6'b000001,L,16'd0));
        foreach (st[i]) begin
            apply(st[i], xq[i]);
            #3;
            e = exp_q.pop_front();
            n_total++;
            if ({sel, stall, stall_cnt} !== {e.sel, e.stall, e.cnt}) begin
                n_bad++;
                $display("FAIL youngest[%0d]: got sel=%b stall=%b cnt=%0d, want sel=%b stall=%b cnt=%0d",
                         i, sel, stall, stall_cnt, e.sel, e.stall, e.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(L,H,L,H,4'd5,H,H,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd6,H,L,12'h005,3'b001)); xq.push_back(ex(6'b000000,H,16'd0));
        st.push_back(mk(L,H,L,H,4'd6,H,L,12'h005,3'b001)); xq.push_back(ex(6'b000010,L,16'd1));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h065,3'b011)); xq.push_back(ex(6'b000111,L,16'd1));
        foreach (st[i]) begin
            apply(st[i], xq[i]);
            #3;
            e = exp_q.pop_front();
            n_total++;
            if ({sel, stall, stall_cnt} !== {e.sel, e.stall, e.cnt}) begin
                n_bad++;
                $display("FAIL load_use[%0d]: got sel=%b stall=%b cnt=%0d, want sel=%b stall=%b cnt=%0d",
                         i, sel, stall, stall_cnt, e.sel, e.stall, e.cnt);
            end
        end
    endtask

    task automatic test_interlock();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(L,L,L,H,4'd2,H,L,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,L,L,H,4'd4,H,L,12'h002,3'b001)); xq.push_back(ex(6'b000000,H,16'd0));
        st.push_back(mk(L,L,L,H,4'd4,H,L,12'h002,3'b001)); xq.push_back(ex(6'b000000,H,16'd1));
        st.push_back(mk(L,L,L,H,4'd4,H,L,12'h002,3'b001)); xq.push_back(ex(6'b000000,H,16'd2));
        st.push_back(mk(L,L,L,H,4'd4,H,L,12'h002,3'b001)); xq.push_back(ex(6'b000000,L,16'd3));
        st.push_back(mk(L,L,L,H,4'd0,L,L,12'h400,3'b100)); xq.push_back(ex(6'b000000,H,16'd3));
        foreach (st[i]) begin
            apply(st[i], xq[i]);
            #3;
            e = exp_q.pop_front();
            n_total++;
            if ({sel, stall, stall_cnt} !== {e.sel, e.stall, e.cnt}) begin
                n_bad++;
                $display("FAIL interlock[%0d]: got sel=%b stall=%b cnt=%0d, want sel=%b stall=%b cnt=%0d",
                         i, sel, stall, stall_cnt, e.sel, e.stall, e.cnt);
            end
        end
    endtask

    task automatic test_flush();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(L,H,L,H,4'd5,H,H,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,H,H,4'd6,H,L,12'h005,3'b001)); xq.push_back(ex(6'b000000,H,16'd0));
        st.push_back(mk(L,H,L,H,4'd6,H,L,12'h005,3'b001)); xq.push_back(ex(6'b000000,L,16'd1));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h555,3'b111)); xq.push_back(ex(6'b000000,L,16'd1));
        st.push_back(mk(L,H,H,H,4'd7,H,L,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd1));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h777,3'b111)); xq.push_back(ex(6'b000000,L,16'd1));
        foreach (st[i]) begin
            apply(st[i], xq[i]);
            #3;
            e = exp_q.pop_front();
            n_total++;
            if ({sel, stall, stall_cnt} !== {e.sel, e.stall, e.cnt}) begin
                n_bad++;
                $display("FAIL flush[%0d]: got sel=%b stall=%b cnt=%0d, want sel=%b stall=%b cnt=%0d",
                         i, sel, stall, stall_cnt, e.sel, e.stall, e.cnt);
            end
        end
    endtask

    task automatic test_unused_and_invalid();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(L,L,L,H,4'd4,H,L,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,L,L,H,4'd0,L,L,12'h444,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,L,4'd0,L,L,12'h004,3'b001)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h004,3'b001)); xq.push_back(ex(6'b000011,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd9,H,H,12'h000,3'b000)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,L,4'd0,L,L,12'h009,3'b001)); xq.push_back(ex(6'b000000,L,16'd0));
        st.push_back(mk(L,H,L,H,4'd0,L,L,12'h009,3'b001)); xq.push_back(ex(6'b000010,L,16'd0));
        foreach (st[i]) begin
            apply(st[i], xq[i]);
            #3;
            e = exp_q.pop_front();
            n_total++;
            if ({sel, stall, stall_cnt} !== {e.sel, e.stall, e.cnt}) begin
                n_bad++;
                $display("FAIL unused[%0d]: got sel=%b stall=%b cnt=%0d, want sel=%b stall=%b cnt=%0d",
                         i, sel, stall, stall_cnt, e.sel, e.stall, e.cnt);
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        do_reset();
        // Self-dependent producer in interlock mode: issue, then stall until it drains.
        apply(mk(L,L,L,H,4'd1,H,L,12'h001,3'b001), ex(6'b000000,L,16'd15));
        repeat (16) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_total++;
        if ({sel_deep, stall_deep, cnt_deep} !== {12'h000, e.stall, e.cnt}) begin
            n_bad++;
            $display("FAIL saturate_early: got sel=%h stall=%b cnt=%0d, want sel=000 stall=%b cnt=%0d",
                     sel_deep, stall_deep, cnt_deep, e.stall, e.cnt);
        end
        exp_q.push_back(ex(6'b000000,L,16'hFFFF));
        repeat (70000) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_total++;
        if ({sel_deep, stall_deep, cnt_deep} !== {12'h000, e.stall, e.cnt}) begin
            n_bad++;
            $display("FAIL saturate_hold: got sel=%h stall=%b cnt=%h, want sel=000 stall=%b cnt=%h",
                     sel_deep, stall_deep, cnt_deep, e.stall, e.cnt);
        end
    endtask

    initial begin
        rst = H; en = H; flush = L; id_valid = L; id_dest = 4'd0;
        id_wb_en = L; id_mem_read = L; src_addr = 12'h000; src_used = 3'b000;
        test_reset();
        test_fwd_single();
        test_youngest();
        test_load_use();
        test_interlock();
        test_flush();
        test_unused_and_invalid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
